// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and constants for the multi-cycle shift sequencer
// Optional feature macro: SHIFT_SEQ_ROTR_EN (op=11 rotates right when defined,
// otherwise op=11 passes the operand through unchanged).
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_ROTR = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    localparam int SHIFT_STEP_DEFAULT = 2;

`ifdef SHIFT_SEQ_ROTR_EN
    localparam bit ROTR_EN = 1'b1;
`else
    localparam bit ROTR_EN = 1'b0;
`endif

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single shift stage, shifts value_in by k positions
// Ports:
//   value_in  [WIDTH-1:0]  value to shift
//   op        [1:0]        00 SLL, 01 SRL, 10 SRA, 11 ROTR (pass-through unless
//                          SHIFT_SEQ_ROTR_EN is defined)
//   k         [K_W-1:0]    positions to shift this stage (0..STEP)
//   value_out [WIDTH-1:0]  shifted value
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int K_W   = 2
) (
    input  logic [WIDTH-1:0] value_in,
    input  logic [1:0]       op,
    input  logic [K_W-1:0]   k,
    output logic [WIDTH-1:0] value_out
);

    always_comb begin
        value_out = value_in;
        case (shift_op_t'(op))
            OP_SLL:  value_out = value_in << k;
            OP_SRL:  value_out = value_in >> k;
            // The sign bit of the work register is the original operand's MSB,
            // and arithmetic shifting preserves it across every stage.
            OP_SRA:  value_out = WIDTH'($signed(value_in) >>> k);
            OP_ROTR: begin
                // k=0 makes the left shift amount WIDTH, which yields zero,
                // so the OR leaves the value intact.
                if (ROTR_EN) begin
                    value_out = (value_in >> k) | (value_in << (WIDTH - int'(k)));
                end
            end
            default: value_out = value_in;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle SLL/SRL/SRA(/ROTR) controller, STEP bits per cycle
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               request, sampled only in IDLE
//   op [1:0]            00 SLL, 01 SRL, 10 SRA, 11 ROTR/pass-through
//   shamt [SHAMT_W-1:0] shift amount 0..WIDTH-1
//   operand [WIDTH-1:0] value to shift
//   busy                high whenever the FSM is not IDLE
//   done                one-cycle pulse in the DONE state
//   result [WIDTH-1:0]  shifted value, held until the next completion
// Optional feature macro: SHIFT_SEQ_ROTR_EN (see shift_pkg).
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int  WIDTH   = 32,
    parameter int  STEP    = SHIFT_STEP_DEFAULT,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   operand,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam int K_W = $clog2(STEP + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    shift_op_t          op_q, op_d;
    logic [SHAMT_W-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [K_W-1:0]     k;
    logic [WIDTH-1:0]   step_out;
    logic               pass_through;

    // Final step may be shorter than STEP so remaining lands exactly on zero.
    assign k = (remaining_q < SHAMT_W'(STEP)) ? K_W'(remaining_q) : K_W'(STEP);

    assign pass_through = (shift_op_t'(op) == OP_ROTR) && !ROTR_EN;

    shift_step #(
        .WIDTH (WIDTH),
        .K_W   (K_W)
    ) u_step (
        .value_in  (work_q),
        .op        (op_q),
        .k         (k),
        .value_out (step_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            op_q        <= OP_SLL;
            remaining_q <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            op_q        <= op_d;
            remaining_q <= remaining_d;
            result_q    <= result_d;
        end
    end

    // result_d is loaded only on the transition into DONE, so result holds
    // its value through IDLE and SHIFT.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        op_d        = op_q;
        remaining_d = remaining_q;
        result_d    = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d      = operand;
                    op_d        = shift_op_t'(op);
                    remaining_d = shamt;
                    if ((shamt == '0) || pass_through) begin
                        state_d  = S_DONE;
                        result_d = operand;
                    end else begin
                        state_d  = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                work_d      = step_out;
                remaining_d = remaining_q - SHAMT_W'(k);
                if (remaining_d == '0) begin
                    state_d  = S_DONE;
                    result_d = step_out;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
        result = result_q;
    end

endmodule
